// File: rtl/mem_loader.sv
// mem_loader: boot-time loader that parses a header/payload word stream and
// writes each payload segment into one of NUM_REGIONS bram32 write ports.
// The core is held in stall until the final segment has been committed, and
// a reload request in RUN re-arms the loader for a fresh image.
module mem_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_REGIONS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   reload,
    output logic [ADDR_WIDTH-1:0]  mem_w_addr,
    output logic [DATA_WIDTH-1:0]  mem_w_dat,
    output logic [NUM_REGIONS-1:0] mem_w_enb,
    output logic [3:0]             mem_byte_enb,
    output logic                   cpu_stall,
    output logic                   load_done,
    output logic                   error
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_DRAIN,
        ST_FLUSH,
        ST_RUN
    } state_t;

    localparam logic [3:0]  NREG_LIM   = 4'(NUM_REGIONS);
    localparam logic [17:0] ADDR_LIMIT = 18'd1 << ADDR_WIDTH;

    state_t                 state_q;
    logic                   ready_q;
    logic                   stall_q;
    logic                   done_q;
    logic                   error_q;
    logic                   final_q;
    logic [2:0]             region_q;
    logic [11:0]            cnt_m1_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [11:0]            idx_q;
    logic [NUM_REGIONS-1:0] wenb_q;
    logic [3:0]             benb_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  dat_q;

    logic                   hdr_final_d;
    logic [2:0]             hdr_region_d;
    logic [11:0]            hdr_cnt_m1_d;
    logic [15:0]            hdr_base_d;
    logic [17:0]            hdr_end_d;
    logic                   hdr_bad_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_d;
    logic [NUM_REGIONS-1:0] wr_enb_d;
    logic                   hs;

    assign hs = s_valid && ready_q;

    // Header field decode and validity check; the end address is formed in
    // 18 bits so a maximal base plus a 4096-word segment cannot wrap.
    always_comb begin
        hdr_final_d  = s_data[31];
        hdr_region_d = s_data[30:28];
        hdr_cnt_m1_d = s_data[27:16];
        hdr_base_d   = {s_data[15:2], 2'b00};
        hdr_end_d    = {2'b00, hdr_base_d} + {4'b0000, hdr_cnt_m1_d, 2'b00} + 18'd4;
        hdr_bad_d    = ({1'b0, hdr_region_d} >= NREG_LIM) || (hdr_end_d > ADDR_LIMIT);
    end

    // Write address for the current payload word and one-hot region enable;
    // an accepted header guarantees the address fits in ADDR_WIDTH bits.
    always_comb begin
        wr_addr_d = base_q + ADDR_WIDTH'({idx_q, 2'b00});
        wr_enb_d  = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if ({1'b0, region_q} == 4'(r)) begin
                wr_enb_d[r] = 1'b1;
            end
        end
    end

    // Loader FSM with registered stream, write-port and core-control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_HDR;
            ready_q  <= 1'b0;
            stall_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            final_q  <= 1'b0;
            region_q <= '0;
            cnt_m1_q <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            wenb_q   <= '0;
            benb_q   <= 4'h0;
            addr_q   <= '0;
            dat_q    <= '0;
        end else begin
            wenb_q <= '0;
            benb_q <= 4'h0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_HDR: begin
                    ready_q <= 1'b1;
                    if (hs) begin
                        final_q  <= hdr_final_d;
                        region_q <= hdr_region_d;
                        cnt_m1_q <= hdr_cnt_m1_d;
                        base_q   <= hdr_base_d[ADDR_WIDTH-1:0];
                        idx_q    <= '0;
                        if (hdr_bad_d) begin
                            error_q <= 1'b1;
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD, ST_DRAIN: begin
                    if (hs) begin
                        if (state_q == ST_LOAD) begin
                            wenb_q <= wr_enb_d;
                            benb_q <= 4'hF;
                            addr_q <= wr_addr_d;
                            dat_q  <= s_data;
                        end
                        if (idx_q == cnt_m1_q) begin
                            if (final_q) begin
                                state_q <= ST_FLUSH;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_HDR;
                            end
                        end else begin
                            idx_q <= idx_q + 12'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                    stall_q <= 1'b0;
                end
                ST_RUN: begin
                    if (reload) begin
                        error_q <= 1'b0;
                        stall_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_HDR;
                    end
                end
                default: begin
                    state_q <= ST_HDR;
                end
            endcase
        end
    end

    assign s_ready      = ready_q;
    assign mem_w_addr   = addr_q;
    assign mem_w_dat    = dat_q;
    assign mem_w_enb    = wenb_q;
    assign mem_byte_enb = benb_q;
    assign cpu_stall    = stall_q;
    assign load_done    = done_q;
    assign error        = error_q;

endmodule
